inst_split_pipe: RTL and testbench
==================================

// Module: inst_split_pipe
// PURPOSE
//  Registered, parametrised successor to the combinational instruction field splitter.
//  Sits between ROM fetch and execute.
//  Accepts one instruction word per cycle over a valid/ready handshake.
//  Splits the word into cond/opcd/dest/source/source2 fields, plus a derived immediate and class flags.
//  Holds up to DEPTH decoded entries so fetch can keep streaming while execute stalls; flush drops all held work.
// PARAMETERS
//  INST_W   16  instruction width
//  COND_W   2   condition field width (MSBs)
//  OPCD_W   4   opcode field width
//  REG_W    3   dest/source register index width
//  SRC2_W   INST_W-COND_W-OPCD_W-2*REG_W (=4)  source2/shift field width (LSBs); must be >=1
//  DEPTH    2   decoded-entry buffer depth, power of 2, >=2
//  IMM_OPCD 4'hF  opcode whose source/source2 form an immediate
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous, active-high reset
//  flush      in   1        synchronous discard of all buffered entries
//  in_valid   in   1        inst is valid
//  in_ready   out  1        block can accept inst this cycle
//  inst       in   INST_W   instruction word from ROM
//  out_valid  out  1        head entry is valid
//  out_ready  in   1        consumer takes head entry this cycle
//  cond       out  COND_W   inst[INST_W-1 -: COND_W]
//  opcd       out  OPCD_W   next OPCD_W bits below cond
//  dest       out  REG_W    next REG_W bits
//  source     out  REG_W    next REG_W bits
//  source2    out  SRC2_W   inst[SRC2_W-1:0]
//  imm        out  REG_W+SRC2_W  {source,source2} when opcd==IMM_OPCD, else 0
//  is_imm     out  1        opcd==IMM_OPCD
//  is_nop     out  1        entire inst word == 0
//  count      out  $clog2(DEPTH)+1  entries held
// BEHAVIOUR
//  Reset (async assert, any time):
//   - count=0, out_valid=0, all field outputs 0, in_ready=1.
//   - Buffer pointers cleared; stored entries are lost.
//   - Outputs leave reset values only after the first accepted inst.
//  Handshake:
//   - Accept when in_valid&in_ready; pop when out_valid&out_ready.
//   - Producer may hold in_valid with inst stable; consumer sees head fields stable while out_valid&!out_ready.
//  Latency: accepted inst appears at outputs the next cycle if the buffer was empty (1-cycle latency).
//  Buffer: circular, DEPTH entries, wr/rd pointers wrap modulo DEPTH.
//   - Decode performed at write; each entry stores the fields + flags.
//  in_ready = (count<DEPTH) | out_ready.
//   - Full with simultaneous pop: accept allowed, count unchanged.
//   - Empty: no bypass, out_valid=0 same cycle as accept.
//  Simultaneous push+pop: count unchanged; both pointers advance.
//  Outputs are driven from head entry; when out_valid=0 the fields hold 0.
//  flush: next cycle count=0 and out_valid=0; a push in the flush cycle is discarded; flush overrides pop.
//  Widths: all fields are zero-extended slices; imm is zero-extended and unsigned.
//  Elaboration error if SRC2_W<1 or DEPTH not a power of 2.
// STRUCTURE
//  Shared package holds:
//   - default widths COND_W/OPCD_W/REG_W;
//   - IMM_OPCD and the opcode constants;
//   - a decoded-instruction struct (cond, opcd, dest, source, source2, imm, is_imm, is_nop).
//  Sub-module inst_field_decode: pure combinational split of one word into the struct; instantiated once at the write port.
//  Top holds the buffer array, pointers, count and handshake logic.
// TESTING
//  1. inst=16'b0000010010100000, out_ready=1 -> next cycle out_valid=1, opcd=1, dest=1, source=2, source2=0, cond=0.
//  2. inst=16'b1111110101101010 -> cond=3, opcd=15, dest=2, source=6, source2=10, is_imm=1, imm=7'h6A.
//  3. out_ready=0, stream 3 words -> first two accepted (count=2), in_ready=0 on third.
//     Raise out_ready -> words emerge in order; no loss or duplicate.
//  4. Full buffer, push+pop same cycle -> count stays 2, pointers wrap, order preserved over 8 words.
//  5. flush with count=2 and in_valid=1 -> next cycle count=0, out_valid=0, pushed word dropped.
//  6. Assert rst mid-stream (async, between edges) -> immediately out_valid=0, count=0, fields 0, in_ready=1.

Source files
------------

// File: rtl/inst_split_pipe_pkg.sv
// Shared widths, opcode constants and the decoded-instruction record used by
// the instruction splitter pipeline.
package inst_split_pipe_pkg;

    localparam int INST_W = 16;
    localparam int COND_W = 2;
    localparam int OPCD_W = 4;
    localparam int REG_W  = 3;
    localparam int SRC2_W = INST_W - COND_W - OPCD_W - 2*REG_W;
    localparam int IMM_W  = REG_W + SRC2_W;

    localparam logic [OPCD_W-1:0] IMM_OPCD = 4'hF;

    typedef struct packed {
        logic [COND_W-1:0] cond;
        logic [OPCD_W-1:0] opcd;
        logic [REG_W-1:0]  dest;
        logic [REG_W-1:0]  source;
        logic [SRC2_W-1:0] source2;
        logic [IMM_W-1:0]  imm;
        logic              is_imm;
        logic              is_nop;
    } decoded_t;

endpackage

// File: rtl/inst_field_decode.sv
// Pure combinational split of one instruction word into its fields and class
// flags; sits at the buffer write port so entries are stored already decoded.
module inst_field_decode
    import inst_split_pipe_pkg::*;
#(
    parameter logic [OPCD_W-1:0] IMM_OP = IMM_OPCD
) (
    input  logic [INST_W-1:0] inst,
    output decoded_t          dec
);

    always_comb begin
        dec         = '0;
        dec.cond    = inst[INST_W-1 -: COND_W];
        dec.opcd    = inst[INST_W-COND_W-1 -: OPCD_W];
        dec.dest    = inst[INST_W-COND_W-OPCD_W-1 -: REG_W];
        dec.source  = inst[SRC2_W+REG_W-1 -: REG_W];
        dec.source2 = inst[SRC2_W-1:0];
        dec.is_imm  = (dec.opcd == IMM_OP);
        dec.imm     = dec.is_imm ? {dec.source, dec.source2} : '0;
        dec.is_nop  = (inst == '0);
    end

endmodule

// File: rtl/inst_split_pipe.sv
// Registered instruction splitter: valid/ready input, DEPTH-entry circular
// buffer of decoded instructions, head entry presented on the outputs.
module inst_split_pipe
    import inst_split_pipe_pkg::*;
#(
    parameter int                DEPTH  = 2,
    parameter logic [OPCD_W-1:0] IMM_OP = IMM_OPCD
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INST_W-1:0]       inst,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [COND_W-1:0]       cond,
    output logic [OPCD_W-1:0]       opcd,
    output logic [REG_W-1:0]        dest,
    output logic [REG_W-1:0]        source,
    output logic [SRC2_W-1:0]       source2,
    output logic [IMM_W-1:0]        imm,
    output logic                    is_imm,
    output logic                    is_nop,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    if (SRC2_W < 1) begin : g_bad_src2
        $error("inst_split_pipe: source2 field width must be at least 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("inst_split_pipe: DEPTH must be a power of 2 and at least 2");
    end

    decoded_t dec;

    inst_field_decode #(.IMM_OP(IMM_OP)) u_decode (
        .inst (inst),
        .dec  (dec)
    );

    decoded_t          mem_q [DEPTH];
    decoded_t          mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push, pop;
    decoded_t          head;

    always_comb begin
        out_valid = (count_q != '0);
        in_ready  = (count_q < DEPTH_C) | out_ready;
        push      = in_valid & in_ready & ~flush;
        pop       = out_valid & out_ready & ~flush;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Flush wins over both a same-cycle push and pop.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = dec;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        head = out_valid ? mem_q[rd_ptr_q] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign cond    = head.cond;
    assign opcd    = head.opcd;
    assign dest    = head.dest;
    assign source  = head.source;
    assign source2 = head.source2;
    assign imm     = head.imm;
    assign is_imm  = head.is_imm;
    assign is_nop  = head.is_nop;
    assign count   = count_q;

endmodule

// File: tb/tb_inst_split_pipe.sv
// Scoreboard bench for inst_split_pipe: accepted words are decoded by an
// arithmetic reference model and queued; a negedge monitor checks the head.
module tb_inst_split_pipe;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] inst = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  cond;
    logic [3:0]  opcd;
    logic [2:0]  dest;
    logic [2:0]  source;
    logic [3:0]  source2;
    logic [6:0]  imm;
    logic        is_imm;
    logic        is_nop;
    logic [1:0]  count;

    inst_split_pipe #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst      (inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cond      (cond),
        .opcd      (opcd),
        .dest      (dest),
        .source    (source),
        .source2   (source2),
        .imm       (imm),
        .is_imm    (is_imm),
        .is_nop    (is_nop),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cond, opcd, dest, source, source2, imm, is_imm, is_nop;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    function automatic exp_t ref_decode(input logic [15:0] w);
        exp_t e;
        int   v;
        v         = int'(w);
        e.cond    = v / 16384;
        e.opcd    = (v / 1024) % 16;
        e.dest    = (v / 128) % 8;
        e.source  = (v / 16) % 8;
        e.source2 = v % 16;
        e.is_imm  = (e.opcd == 15) ? 1 : 0;
        e.imm     = e.is_imm ? (v % 128) : 0;
        e.is_nop  = (v == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_fields(input exp_t e);
        chk("cond", int'(cond), e.cond);
        chk("opcd", int'(opcd), e.opcd);
        chk("dest", int'(dest), e.dest);
        chk("source", int'(source), e.source);
        chk("source2", int'(source2), e.source2);
        chk("imm", int'(imm), e.imm);
        chk("is_imm", int'(is_imm), e.is_imm);
        chk("is_nop", int'(is_nop), e.is_nop);
    endtask

    // Monitor: queue state at a negedge describes what the DUT should hold now.
    always @(negedge clk) begin
        if (!rst) begin
            exp_t zero;
            zero = '{default: 0};
            chk("count", int'(count), q.size());
            chk("out_valid", int'(out_valid), (q.size() != 0) ? 1 : 0);
            chk("in_ready", int'(in_ready), (q.size() < DEPTH || out_ready) ? 1 : 0);
            if (q.size() != 0) begin
                chk_fields(q[0]);
                if (out_ready && !flush) void'(q.pop_front());
            end else begin
                chk_fields(zero);
            end
        end
    end

    // Called at posedge+1; returns at the following posedge+1.
    task automatic step(input logic v, input logic [15:0] w, input logic ordy,
                        input logic fl, output bit acc);
        in_valid  = v;
        inst      = w;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        acc = in_valid && in_ready && !flush;
        #1;
        if (fl) q.delete();
        else if (acc) q.push_back(ref_decode(w));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        w = 16'($urandom);
        if ($urandom_range(3) == 0) w[13:10] = 4'hF;
        if ($urandom_range(15) == 0) w = '0;
        return w;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit          acc;
        logic [15:0] w;
        bit          pend;

        @(posedge clk); #1;
        chk("rst_count", int'(count), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_opcd", int'(opcd), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic split, 1-cycle latency
        step(1, 16'b0000010010100000, 1, 0, acc);
        in_valid = 0;
        @(negedge clk);
        chk("t1_out_valid", int'(out_valid), 1);
        chk("t1_cond", int'(cond), 0);
        chk("t1_opcd", int'(opcd), 1);
        chk("t1_dest", int'(dest), 1);
        chk("t1_source", int'(source), 2);
        chk("t1_source2", int'(source2), 0);
        @(posedge clk); #1;

        // Immediate form
        step(1, 16'b1111110101101010, 1, 0, acc);
        in_valid = 0;
        @(negedge clk);
        chk("t2_cond", int'(cond), 3);
        chk("t2_opcd", int'(opcd), 15);
        chk("t2_dest", int'(dest), 2);
        chk("t2_source", int'(source), 6);
        chk("t2_source2", int'(source2), 10);
        chk("t2_is_imm", int'(is_imm), 1);
        chk("t2_imm", int'(imm), 8'h6A);
        @(posedge clk); #1;

        // Backpressure: third word refused while full and stalled
        step(1, 16'h1234, 0, 0, acc);
        step(1, 16'h5678, 0, 0, acc);
        in_valid = 1; inst = 16'h9ABC; out_ready = 0;
        @(negedge clk);
        chk("t3_count_full", int'(count), 2);
        chk("t3_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        step(1, 16'h9ABC, 1, 0, acc);
        chk("t3_accept_on_pop", int'(acc), 1);
        for (int i = 0; i < 3; i++) step(0, 16'h0, 1, 0, acc);

        // Full buffer with continuous push+pop over 8 words
        step(1, rand_word(), 0, 0, acc);
        step(1, rand_word(), 0, 0, acc);
        for (int i = 0; i < 8; i++) begin
            step(1, rand_word(), 1, 0, acc);
            chk("t4_count_steady", int'(count), 2);
        end
        for (int i = 0; i < 3; i++) step(0, 16'h0, 1, 0, acc);

        // Flush with a pending push
        step(1, 16'h1111, 0, 0, acc);
        step(1, 16'h2222, 0, 0, acc);
        step(1, 16'h3333, 1, 1, acc);
        in_valid = 0;
        @(negedge clk);
        chk("t5_count", int'(count), 0);
        chk("t5_out_valid", int'(out_valid), 0);
        @(posedge clk); #1;

        // Randomized traffic; producer holds a refused word stable
        pend = 0;
        w    = '0;
        for (int i = 0; i < 300; i++) begin
            bit v;
            if (!pend) w = rand_word();
            v = pend || ($urandom_range(3) != 0);
            step(v, w, ($urandom_range(2) != 0), ($urandom_range(24) == 0), acc);
            pend = v && !acc && !flush;
        end
        for (int i = 0; i < 3; i++) step(0, 16'h0, 1, 0, acc);

        // Asynchronous reset between edges while holding two entries
        step(1, 16'hABCD, 0, 0, acc);
        step(1, 16'hFFFF, 0, 0, acc);
        in_valid = 0;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_out_valid", int'(out_valid), 0);
        chk("t6_count", int'(count), 0);
        chk("t6_in_ready", int'(in_ready), 1);
        chk("t6_opcd", int'(opcd), 0);
        chk("t6_imm", int'(imm), 0);
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        step(1, 16'h0C35, 1, 0, acc);
        for (int i = 0; i < 3; i++) step(0, 16'h0, 1, 0, acc);

        chk("sb_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
